tvs_sweep_ctrl: RTL
===================

# tvs_sweep_ctrl

Sequencer for the on-die temperature/voltage sensor (TVS) core. On a start request it enables the selected sensor channels and collects 2^AVG_LOG2 conversions per channel. It then publishes per-channel averaged results, flags over-temperature, and de-asserts the channel enables to save power. It sits between the TVS core outputs and the slow-control register space, which reads results through a small registered read port.

## Interface
Parameters:
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
- TIMEOUT_CYCLES, 1000000, max cycles between accepted samples before abort
- TO_W, 20, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  single-cycle sweep request
- CH_MASK  in  4  channels to sweep, latched at START: bit0 temp, bit1 1V, bit2 1.8V, bit3 2.5V
- TEMP_LIMIT  in  16  over-temperature threshold, raw TVS units, latched at START
- ALARM_CLR  in  1  clears OVERTEMP and ERR
- ENABLE_TEMP / ENABLE_1V / ENABLE_18V / ENABLE_25V  out  1 each  TVS channel enables
- TVS_ACTIVE  in  1  TVS ACTIVE
- TVS_CHANNEL  in  2  TVS CHANNEL, 0 temp, 1 1V, 2 1.8V, 3 2.5V
- TVS_VALID  in  1  TVS VALID, single-cycle
- TVS_VALUE  in  16  TVS VALUE
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle pulse at sweep end (success or abort)
- ERR  out  1  sticky, timeout abort occurred
- OVERTEMP  out  1  sticky, averaged temp > TEMP_LIMIT
- RD_EN  in  1  read strobe
- RD_ADDR  in  2  result index, same encoding as TVS_CHANNEL
- RD_DATA  out  16  averaged result
- RD_VALID  out  1  RD_DATA qualifier

## Operation
- States: IDLE, WAIT_ACT, COLLECT.
- IDLE: if START=1, latch CH_MASK and TEMP_LIMIT, then clear accumulators, per-channel counters and the timeout counter.
  - If the mask is non-zero, go to WAIT_ACT.
  - If the mask is 0, stay in IDLE and pulse DONE the next cycle. Results are unchanged.
- WAIT_ACT: enables = latched mask. Go to COLLECT when TVS_ACTIVE=1.
- COLLECT: accept a sample when TVS_VALID=1, the mask bit for TVS_CHANNEL is set, and that channel's count is < 2^AVG_LOG2.
  - Add TVS_VALUE to that channel's accumulator (16+AVG_LOG2 bits, no overflow possible).
  - Increment the channel's count.
- Samples are ignored when they arrive on an unmasked channel, on a channel whose count is full, or while in WAIT_ACT.
- Completion: when every masked channel's count reaches 2^AVG_LOG2, the following take effect on the next edge:
  - result[ch] = acc[ch] >> AVG_LOG2 (truncating) for masked channels only; unmasked results retain their old value.
  - OVERTEMP set if the temp channel is masked and result[0] > TEMP_LIMIT (unsigned compare).
  - DONE=1 for one cycle; enables=0; BUSY=0; state returns to IDLE.
- Timeout: the counter runs in WAIT_ACT and COLLECT and resets on each accepted sample. When it reaches TIMEOUT_CYCLES-1:
  - ERR=1, DONE pulses, enables=0, return to IDLE.
  - No result or OVERTEMP is updated.
- START while BUSY is ignored.
- ALARM_CLR clears OVERTEMP and ERR. If set and clear fall in the same cycle, set wins.
- RD_EN ignores BUSY. Reads return the stored result; partial accumulations are never visible.

## Timing
- Reset values: all enables 0, BUSY 0, DONE 0, ERR 0, OVERTEMP 0, RD_DATA 0x0000, RD_VALID 0, all results 0x0000, state IDLE.
- START sampled at edge k gives BUSY=1 and enables asserted from edge k+1.
- Last accepted TVS_VALID at edge k gives results, OVERTEMP, DONE=1, BUSY=0 and enables=0 all at edge k+1.
- RD_EN at edge k gives RD_DATA/RD_VALID at edge k+1, with RD_VALID high for one cycle.
  - A read coinciding with the result-update edge returns the pre-update value.
- An accepted sample on the edge where the timeout would fire counts as a sample; the timeout does not fire.
- RESET_N low mid-sweep: outputs go immediately to reset values (asynchronous assert). Deassertion must be synchronous to CLK.

## Test plan
- AVG_LOG2=2, mask 0001: temp samples 100, 102, 104, 106.
  - Response: DONE one cycle after the 4th sample, result[0]=103, BUSY 0, enables 0.
- Mask 1111, TEMP_LIMIT=200: interleaved valids with temp samples 201, 201, 202, 202 and 1V samples 4×0x1000, plus extra 5th/6th samples injected on 1V.
  - Response: result[0]=201, result[1]=0x1000, OVERTEMP=1.
  - Extra 1V samples are ignored; DONE fires only after all four channels reach 4 samples.
- Mask 0010, valids presented on channels 0 and 3 only.
  - Response: no accumulation, no DONE; with TIMEOUT_CYCLES=64, ERR=1 and DONE pulse 64 cycles after TVS_ACTIVE; results unchanged.
- START during BUSY and START with mask 0.
  - Response: the first is ignored; the second gives DONE the next cycle with BUSY never set.
- RD_EN addr 0 on the same edge as completion.
  - Response: old value returned, new value on the following read; ALARM_CLR then drops OVERTEMP and ERR.
- RESET_N pulsed low mid-COLLECT.
  - Response: all outputs 0 immediately; a following START runs a clean sweep with correct averages.

Source files
------------

// File: rtl/tvs_sweep_ctrl.sv
// rtl/tvs_sweep_ctrl.sv - TVS sensor sweep sequencer with per-channel averaging and result read port
module tvs_sweep_ctrl #(
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [3:0]  CH_MASK,
  input  logic [15:0] TEMP_LIMIT,
  input  logic        ALARM_CLR,
  output logic        ENABLE_TEMP,
  output logic        ENABLE_1V,
  output logic        ENABLE_18V,
  output logic        ENABLE_25V,
  input  logic        TVS_ACTIVE,
  input  logic [1:0]  TVS_CHANNEL,
  input  logic        TVS_VALID,
  input  logic [15:0] TVS_VALUE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        OVERTEMP,
  input  logic        RD_EN,
  input  logic [1:0]  RD_ADDR,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACT = 2'd1,
    COLLECT  = 2'd2
  } state_e;

  // Reset asserts immediately, releases only after two clean clock edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  state_e             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [15:0]        limit_q, limit_d;
  logic [3:0]         en_q, en_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ot_q, ot_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [ACC_W-1:0]   acc_q [4];
  logic [ACC_W-1:0]   acc_d [4];
  logic [CNT_W-1:0]   cnt_q [4];
  logic [CNT_W-1:0]   cnt_d [4];
  logic [15:0]        result_q [4];
  logic [15:0]        result_d [4];

  logic accept, all_full, timeout, abort, err_set, ot_set;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    limit_d    = limit_q;
    en_d       = en_q;
    to_cnt_d   = to_cnt_q;
    done_d     = 1'b0;
    err_set    = 1'b0;
    ot_set     = 1'b0;
    abort      = 1'b0;
    rd_valid_d = RD_EN;
    rd_data_d  = RD_EN ? result_q[RD_ADDR] : rd_data_q;
    for (int i = 0; i < 4; i++) begin
      acc_d[i]    = acc_q[i];
      cnt_d[i]    = cnt_q[i];
      result_d[i] = result_q[i];
    end

    accept = (state_q == COLLECT) && TVS_VALID && mask_q[TVS_CHANNEL] &&
             (cnt_q[TVS_CHANNEL] < CNT_FULL);
    if (accept) begin
      acc_d[TVS_CHANNEL] = acc_q[TVS_CHANNEL] + ACC_W'(TVS_VALUE);
      cnt_d[TVS_CHANNEL] = cnt_q[TVS_CHANNEL] + CNT_W'(1);
    end

    // Completion looks at counts including the sample arriving this cycle.
    all_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (mask_q[i] && (cnt_d[i] != CNT_FULL)) all_full = 1'b0;
    end

    timeout = (to_cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (START) begin
          mask_d   = CH_MASK;
          limit_d  = TEMP_LIMIT;
          to_cnt_d = '0;
          for (int i = 0; i < 4; i++) begin
            acc_d[i] = '0;
            cnt_d[i] = '0;
          end
          if (CH_MASK != 4'b0000) begin
            state_d = WAIT_ACT;
            en_d    = CH_MASK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_ACT: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (TVS_ACTIVE) state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && all_full) begin
          for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) result_d[i] = acc_d[i][AVG_LOG2 +: 16];
          end
          if (mask_q[0] && (acc_d[0][AVG_LOG2 +: 16] > limit_q)) ot_set = 1'b1;
          done_d  = 1'b1;
          en_d    = 4'b0000;
          state_d = IDLE;
        end else if (accept) begin
          to_cnt_d = '0;
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      err_set = 1'b1;
      done_d  = 1'b1;
      en_d    = 4'b0000;
      state_d = IDLE;
    end

    // Setting an alarm outranks a simultaneous clear.
    err_d = err_set | (err_q & ~ALARM_CLR);
    ot_d  = ot_set  | (ot_q  & ~ALARM_CLR);
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      limit_q    <= '0;
      en_q       <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ot_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]    <= '0;
        cnt_q[i]    <= '0;
        result_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      limit_q    <= limit_d;
      en_q       <= en_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ot_q       <= ot_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]    <= acc_d[i];
        cnt_q[i]    <= cnt_d[i];
        result_q[i] <= result_d[i];
      end
    end
  end

  assign ENABLE_TEMP = en_q[0];
  assign ENABLE_1V   = en_q[1];
  assign ENABLE_18V  = en_q[2];
  assign ENABLE_25V  = en_q[3];
  assign BUSY        = (state_q != IDLE);
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign OVERTEMP    = ot_q;
  assign RD_DATA     = rd_data_q;
  assign RD_VALID    = rd_valid_q;

endmodule
